pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_pkg.sv | 31 +++
 rtl/pipeline_stall_controller_hazard.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared encodings for the pipeline stall controller:
// immediate types, FSM states, divider defaults and stall bundle.
package pipeline_stall_controller_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_DIV_DONE = 2'd2
  } stall_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic ex_freeze;
    logic if_id_flush;
    logic id_ex_flush;
  } stall_ctl_t;

endpackage

// File: rtl/pipeline_stall_controller_hazard.sv
// Load-use hazard comparator between the EX load
// destination and the ID source operands.
module hazard_detect (
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd_addr,
  output logic       o_load_use
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never written, so a load to it creates no hazard
  assign w_rd_live = i_ex_valid && i_ex_mem_read
                   && (i_ex_rd_addr != 5'd0);

  assign w_rs1_hit = i_rs1_used
                   && (i_ex_rd_addr == i_rs1_addr);

  assign w_rs2_hit = i_rs2_used
                   && (i_ex_rd_addr == i_rs2_addr);

  assign o_load_use = w_rd_live
                    && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: divider sequencing FSM,
// freeze/flush/bubble priority and saturating stall counter.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_div_req,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        ex_freeze,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_done,
  output logic [15:0] stall_count
);

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DIV_CYCLES - 1);

  stall_state_e  r_state;
  stall_state_e  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [15:0]   r_stall_cnt;

  logic       w_load_use;
  logic       w_div_req;
  logic       w_div_freeze;
  logic       w_freeze;
  stall_ctl_t w_ctl;

  hazard_detect u_hazard (
    .i_rs1_addr    (id_rs1_addr),
    .i_rs2_addr    (id_rs2_addr),
    .i_rs1_used    (id_rs1_used),
    .i_rs2_used    (id_rs2_used),
    .i_ex_valid    (ex_valid),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd_addr  (ex_rd_addr),
    .o_load_use    (w_load_use)
  );

  // Only RUN accepts a divide; BUSY/DONE hold the same one
  assign w_div_req = RESET && ex_valid && ex_div_req
                   && (r_state == ST_RUN);

  assign w_div_freeze = w_div_req
    || (RESET && (r_state == ST_DIV_BUSY));

  assign w_freeze = RESET && (mem_busy || w_div_freeze);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_div_req) begin
          w_state_nxt = ST_DIV_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_DIV_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DIV_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_DIV_DONE: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Freeze beats redirect, redirect beats load-use
  always_comb begin
    w_ctl = '0;
    if (!RESET) begin
      w_ctl = '0;
    end else if (w_freeze) begin
      w_ctl.pc_stall    = 1'b1;
      w_ctl.if_id_stall = 1'b1;
      w_ctl.ex_freeze   = 1'b1;
    end else if (branch_taken) begin
      w_ctl.if_id_flush = 1'b1;
      w_ctl.id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_ctl.pc_stall     = 1'b1;
      w_ctl.if_id_stall  = 1'b1;
      w_ctl.id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
    end else if (w_ctl.pc_stall
                 && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pc_stall     = w_ctl.pc_stall;
  assign if_id_stall  = w_ctl.if_id_stall;
  assign id_ex_bubble = w_ctl.id_ex_bubble;
  assign ex_freeze    = w_ctl.ex_freeze;
  assign if_id_flush  = w_ctl.if_id_flush;
  assign id_ex_flush  = w_ctl.id_ex_flush;

  assign div_start = w_div_req;
  assign div_busy  = RESET && (r_state == ST_DIV_BUSY);
  assign div_done  = RESET && (r_state == ST_DIV_DONE);

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed + random bench for pipeline_stall_controller
// against a cycle-count reference model.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int DC = DIV_CYCLES_DEF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used;
  logic        ex_valid, ex_mem_read, ex_div_req;
  logic [4:0]  ex_rd_addr;
  logic        branch_taken, mem_busy;
  logic        pc_stall, if_id_stall, id_ex_bubble;
  logic        ex_freeze, if_id_flush, id_ex_flush;
  logic        div_start, div_busy, div_done;
  logic [15:0] stall_count;
  logic [8:0]  w_out;

  int n_chk = 0;
  int n_fail = 0;

  int m_busy_left;
  bit m_done;
  int m_stall;

  logic [8:0]  s_ctl;
  logic [15:0] s_cnt;

  pipeline_stall_controller #(.DIV_CYCLES(DC)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_valid     (ex_valid),
    .ex_rd_addr   (ex_rd_addr),
    .ex_mem_read  (ex_mem_read),
    .ex_div_req   (ex_div_req),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_bubble (id_ex_bubble),
    .ex_freeze    (ex_freeze),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .stall_count  (stall_count)
  );

  assign w_out = {pc_stall, if_id_stall, id_ex_bubble,
                  ex_freeze, if_id_flush, id_ex_flush,
                  div_start, div_busy, div_done};

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // bits: pc,ifid,bubble,exfrz,iff,idf,start,busy,done
  function automatic logic [8:0] model_ctl();
    logic [8:0] r;
    bit req, lu, frz;
    r = '0;
    if (!RESET) return r;
    req = ex_valid && ex_div_req
          && (m_busy_left == 0) && !m_done;
    lu = ex_valid && ex_mem_read && (ex_rd_addr != 0)
         && ((id_rs1_used && ex_rd_addr == id_rs1_addr)
          || (id_rs2_used && ex_rd_addr == id_rs2_addr));
    frz = mem_busy || req || (m_busy_left > 0);
    if (frz) begin
      r[8] = 1'b1; r[7] = 1'b1; r[5] = 1'b1;
    end else if (branch_taken) begin
      r[4] = 1'b1; r[3] = 1'b1;
    end else if (lu) begin
      r[8] = 1'b1; r[7] = 1'b1; r[6] = 1'b1;
    end
    r[2] = req;
    r[1] = (m_busy_left > 0);
    r[0] = m_done;
    return r;
  endfunction

  task automatic model_step(input logic [8:0] e);
    if (e[8] && m_stall < 65535) m_stall++;
    if (m_done) begin
      m_done = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1;
    end else if (e[2]) begin
      m_busy_left = DC;
    end
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_done = 0;
    m_stall = 0;
  endtask

  task automatic clr();
    id_rs1_addr = '0; id_rs2_addr = '0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_mem_read = 0; ex_div_req = 0;
    ex_rd_addr = '0; branch_taken = 0; mem_busy = 0;
  endtask

  task automatic cyc();
    logic [8:0] e;
    @(negedge CLK);
    e = model_ctl();
    s_ctl = w_out;
    s_cnt = stall_count;
    check("ctl", 32'(s_ctl), 32'(e));
    check("stall_count", 32'(s_cnt), 32'(m_stall));
    @(posedge CLK);
    if (RESET) model_step(e);
    #1;
  endtask

  // inputs left busy while reset asserts
  task automatic apply_reset();
    ex_valid = 1; ex_div_req = 1; mem_busy = 1;
    branch_taken = 1;
    RESET = 0;
    #1;
    model_reset();
    check("rst_ctl", 32'(w_out), 32'h0);
    check("rst_cnt", 32'(stall_count), 32'h0);
    @(posedge CLK);
    #1;
    check("rst_hold_ctl", 32'(w_out), 32'h0);
    clr();
    RESET = 1;
  endtask

  initial begin
    int n_start, n_busy, n_frz, n_done;
    int i_start, i_done;
    clr();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    apply_reset();

    // load-use on rs1
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1;
    cyc();
    check("lu_stall", 32'(s_ctl[8:3]), 32'b111000);
    ex_mem_read = 0;
    cyc();
    check("lu_one_cycle", 32'(s_ctl), 32'h0);

    // x0 destination and unused rs2
    ex_mem_read = 1; ex_rd_addr = 5'd0;
    id_rs1_addr = 5'd0; id_rs1_used = 1;
    cyc();
    check("lu_x0", 32'(s_ctl), 32'h0);
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd3;
    id_rs2_addr = 5'd5; id_rs2_used = 0;
    cyc();
    check("lu_rs2_unused", 32'(s_ctl), 32'h0);
    id_rs2_used = 1;
    cyc();
    check("lu_rs2_used", 32'(s_ctl[8:6]), 32'b111);

    // load-use with coincident branch, then branch under mem_busy
    clr();
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1;
    branch_taken = 1;
    cyc();
    check("br_over_lu", 32'(s_ctl[8:3]), 32'b000011);
    ex_mem_read = 0; mem_busy = 1;
    cyc();
    check("br_frz_a", 32'(s_ctl[4:3]), 32'b00);
    cyc();
    check("br_frz_b", 32'(s_ctl[4:3]), 32'b00);
    mem_busy = 0;
    cyc();
    check("br_after_frz", 32'(s_ctl[4:3]), 32'b11);

    // full divide
    apply_reset();
    ex_valid = 1; ex_div_req = 1;
    n_start = 0; n_busy = 0; n_frz = 0; n_done = 0;
    i_start = -1; i_done = -1;
    for (int i = 0; i < DC + 4; i++) begin
      cyc();
      if (s_ctl[2]) begin n_start++; i_start = i; end
      if (s_ctl[1]) n_busy++;
      if (s_ctl[5]) n_frz++;
      if (s_ctl[0]) begin
        n_done++; i_done = i;
        ex_valid = 0; ex_div_req = 0;
      end
    end
    check("div_start_n", 32'(n_start), 32'd1);
    check("div_busy_n", 32'(n_busy), 32'(DC));
    check("div_frz_n", 32'(n_frz), 32'(DC + 1));
    check("div_done_n", 32'(n_done), 32'd1);
    check("div_latency", 32'(i_done - i_start),
          32'(DC + 1));
    check("div_stall_cnt", 32'(stall_count),
          32'(DC + 1));

    // mem_busy straddling div_done
    apply_reset();
    ex_valid = 1; ex_div_req = 1;
    n_frz = 0; n_done = 0; i_start = -1; i_done = -1;
    for (int i = 0; i < DC + 8; i++) begin
      mem_busy = (i >= DC - 4) && (i <= DC + 4);
      cyc();
      if (s_ctl[2]) i_start = i;
      if (s_ctl[0]) begin
        n_done++; i_done = i;
        ex_valid = 0; ex_div_req = 0;
      end
      if (i <= DC + 4 && s_ctl[5]) n_frz++;
    end
    mem_busy = 0;
    check("mb_frz_cont", 32'(n_frz), 32'(DC + 5));
    check("mb_done_n", 32'(n_done), 32'd1);
    check("mb_latency", 32'(i_done - i_start),
          32'(DC + 1));

    // reset in busy cycle 10
    apply_reset();
    ex_valid = 1; ex_div_req = 1;
    for (int i = 0; i < 10; i++) cyc();
    check("pre_rst_busy", 32'(div_busy), 32'd1);
    mem_busy = 1;
    RESET = 0;
    #1;
    model_reset();
    check("mid_rst_ctl", 32'(w_out), 32'h0);
    check("mid_rst_cnt", 32'(stall_count), 32'h0);
    @(posedge CLK);
    #1;
    check("mid_rst_hold", 32'(w_out), 32'h0);
    clr();
    RESET = 1;
    n_busy = 0; n_done = 0;
    for (int i = 0; i < DC + 8; i++) begin
      cyc();
      if (s_ctl[1]) n_busy++;
      if (s_ctl[0]) n_done++;
      if (i == 0)
        check("post_rst_cnt", 32'(s_cnt), 32'h0);
    end
    check("abort_busy", 32'(n_busy), 32'd0);
    check("abort_done", 32'(n_done), 32'd0);

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_mem_read  = $urandom_range(0, 1);
      ex_div_req   = ($urandom_range(0, 15) == 0);
      ex_rd_addr   = 5'($urandom_range(0, 3));
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      id_rs1_used  = $urandom_range(0, 1);
      id_rs2_used  = $urandom_range(0, 1);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 3) == 0);
      cyc();
    end

    // saturation
    apply_reset();
    mem_busy = 1;
    repeat (65534) @(posedge CLK);
    #1;
    m_stall = 65534;
    check("sat_pre", 32'(stall_count), 32'h0000FFFE);
    repeat (3) cyc();
    check("sat_final", 32'(stall_count), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
